mdu_iter: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the execute stage. It replaces the single-cycle multiplier with a start/busy/done engine for signed and unsigned multiply and divide, writing a {hi, lo} result pair. The pipeline stalls on `busy` and forwards `hi`/`lo` into the HI/LO registers when `done` pulses.

---
 rtl/mdu_iter_pkg.sv | 26 ++
 rtl/mdu_iter_if.sv | 29 ++
 rtl/mdu_iter_div_core.sv | 67 ++++++
 rtl/mdu_iter.sv | 151 +++++++++++++++
 tb/tb_mdu_iter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Operation and FSM state encodings used by the MDU and its users.
package mdu_iter_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } mdu_state_t;

    function automatic logic op_is_div(input mdu_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the execute stage and the MDU.
// The stage drives the request side, the MDU drives status and results.
interface mdu_iter_if
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic             flush;
    logic             start;
    mdu_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output flush, start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  flush, start, op, a, b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_iter_div_core.sv
// Restoring radix-2 divider datapath: one quotient bit per enable.
// Results are the sign-corrected values after the step in progress.
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_en,
    input  logic             i_sgn,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem
);

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic             r_qneg;
    logic             r_rneg;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_quo_n;
    logic [WIDTH-1:0] w_rem_n;

    assign w_a_neg = i_sgn & i_a[WIDTH-1];
    assign w_b_neg = i_sgn & i_b[WIDTH-1];
    assign w_abs_a = w_a_neg ? -i_a : i_a;
    assign w_abs_b = w_b_neg ? -i_b : i_b;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_ge    = ~w_diff[WIDTH];
    assign w_rem_n = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_n = {r_quo[WIDTH-2:0], w_ge};

    // Quotient negates on differing signs, remainder follows the dividend
    assign o_quo = r_qneg ? -w_quo_n : w_quo_n;
    assign o_rem = r_rneg ? -w_rem_n : w_rem_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
        end else if (i_load) begin
            r_quo  <= w_abs_a;
            r_rem  <= '0;
            r_div  <= w_abs_b;
            r_qneg <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
        end else if (i_en) begin
            r_quo  <= w_quo_n;
            r_rem  <= w_rem_n;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit with start/busy/done handshake.
// Holds the FSM, iteration counter, multiplier and result registers.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    mdu_iter_if.slave  bus
);

    localparam int MAXL = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CW   = $clog2(MAXL + 1);

    mdu_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_lim;
    mdu_op_t          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_spec;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic               w_accept;
    logic               w_in_div;
    logic               w_in_spec;
    logic               w_sgn;
    logic [2*WIDTH-1:0] w_pa;
    logic [2*WIDTH-1:0] w_pb;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_accept = (r_state == S_IDLE) & bus.start & ~bus.flush;
    assign w_in_div = op_is_div(bus.op);

    // Zero divisor or MIN / -1 finish after a single busy cycle
    assign w_in_spec = w_in_div & ((bus.b == '0) |
        ((bus.op == DIV) &
         (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) &
         (bus.b == '1)));

    assign w_sgn  = op_is_signed(r_op);
    assign w_pa   = {{WIDTH{w_sgn & r_a[WIDTH-1]}}, r_a};
    assign w_pb   = {{WIDTH{w_sgn & r_b[WIDTH-1]}}, r_b};
    assign w_prod = w_pa * w_pb;

    mdu_div_core #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept & w_in_div),
        .i_en   (r_state == S_DIV),
        .i_sgn  (bus.op == DIV),
        .i_a    (bus.a),
        .i_b    (bus.b),
        .o_quo  (w_quo),
        .o_rem  (w_rem)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_lim   <= '0;
            r_op    <= MULT;
            r_a     <= '0;
            r_b     <= '0;
            r_spec  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.flush) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_op    <= bus.op;
                            r_a     <= bus.a;
                            r_b     <= bus.b;
                            r_spec  <= w_in_spec;
                            r_cnt   <= CW'(1);
                            r_busy  <= 1'b1;
                            if (!w_in_div) begin
                                r_lim   <= CW'(MUL_CYCLES);
                                r_state <= S_MUL;
                            end else begin
                                r_lim   <= w_in_spec ? CW'(1) : CW'(WIDTH);
                                r_state <= S_DIV;
                            end
                        end
                    end
                    S_MUL: begin
                        if (r_cnt == r_lim) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_cnt   <= '0;
                            r_hi    <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo    <= w_prod[WIDTH-1:0];
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_DIV: begin
                        if (r_cnt == r_lim) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_cnt   <= '0;
                            if (!r_spec) begin
                                r_hi <= w_rem;
                                r_lo <= w_quo;
                            end else if (r_b == '0) begin
                                r_hi <= r_a;
                                r_lo <= '1;
                            end else begin
                                r_hi <= '0;
                                r_lo <= r_a;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32, MUL_CYCLES=2).
// Directed cases from the test plan plus random ops against a reference.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic [63:0] last_res;

    mdu_iter_if #(.WIDTH(32)) bus ();

    mdu_iter #(
        .WIDTH      (32),
        .MUL_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_res(input mdu_op_t op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sp;
        int     sq;
        int     sr;
        logic [63:0] up;
        case (op)
            MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {32'd0, a};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
        endcase
    endfunction

    function automatic int ref_lat(input mdu_op_t op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op == MULT || op == MULTU) return 3;
        if (b == 0) return 2;
        if (op == DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 33;
    endfunction

    // Issue in the current cycle, wait for done; optional extra start at poke
    task automatic run(input string tag, input mdu_op_t op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int poke);
        logic [63:0] e;
        int lat;
        int cyc;
        bit busy_ok;
        e   = ref_res(op, a, b);
        lat = ref_lat(op, a, b);
        bus.start = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!bus.done && cyc < 60) begin
            if (!bus.busy) busy_ok = 1'b0;
            bus.start = (cyc == poke);
            if (cyc == poke) begin
                bus.op = MULTU;
                bus.a  = $urandom;
                bus.b  = $urandom;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'(lat));
        check({tag, "_busywin"}, 64'(busy_ok), 64'd1);
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_result"}, {bus.hi, bus.lo}, e);
        last_res = e;
    endtask

    task automatic no_done(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (bus.done) seen = 1'b1;
            @(posedge clk); #1;
        end
        check({tag, "_nodone"}, 64'(seen), 64'd0);
    endtask

    initial begin
        mdu_op_t rop;
        logic [31:0] ra;
        logic [31:0] rb;
        n_cmp = 0;
        n_err = 0;
        last_res = '0;
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        bus.op = MULT;
        bus.a = '0;
        bus.b = '0;
        #1;
        check("reset_out",
              {bus.busy, bus.done, bus.hi, bus.lo}, 66'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 0);
        check("done_pulse", 64'(bus.done), 64'd1);
        @(posedge clk); #1;
        check("done_single", 64'(bus.done), 64'd0);
        run("multu", MULTU, 32'hFFFF_FFFD, 32'd7, 0);
        run("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run("divu", DIVU, 32'd100, 32'd7, 0);
        run("divu_zero", DIVU, 32'h1234, 32'd0, 0);
        run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run("div_poke", DIV, 32'h7654_3210, 32'hFFFF_FF13, 5);
        run("b2b_mult", MULT, 32'h1234_5678, 32'h8765_4321, 0);

        // Flush in cycle 10 of a divide
        bus.start = 1'b1;
        bus.op = DIV;
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        no_done("flush", 40);
        check("flush_hold", {bus.hi, bus.lo}, last_res);

        // Asynchronous reset during a multiply
        bus.start = 1'b1;
        bus.op = MULT;
        bus.a = 32'd9;
        bus.b = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid",
              {bus.busy, bus.done, bus.hi, bus.lo}, 66'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        no_done("rst_mid", 5);

        // Flush together with start drops the request
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op = DIVU;
        bus.a = 32'd50;
        bus.b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_busy", 64'(bus.busy), 64'd0);
        no_done("flush_start", 40);

        for (int i = 0; i < 24; i++) begin
            rop = mdu_op_t'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                3: ra = $urandom_range(0, 255);
                default: ;
            endcase
            run($sformatf("rnd%0d", i), rop, ra, rb, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
